// File: rtl/tx_intf_irq_pkg.sv
// Shared definitions for the tx interrupt status slice: FSM state encoding,
// tx event source indices, default sizing and a select-width helper.
package tx_intf_irq_pkg;

  // Default sizing of the status block
  localparam int DEFAULT_NUM_SRC       = 5;
  localparam int DEFAULT_CNT_WIDTH     = 8;
  localparam int DEFAULT_HOLDOFF_WIDTH = 16;

  // Bit positions of the tx event sources in src_event / pending / overflow
  localparam int SRC_TLAST        = 0;  // s00_axis_tlast
  localparam int SRC_PHY_TX_START = 1;  // phy_tx_start
  localparam int SRC_TX_START_ACC = 2;  // tx_start_from_acc
  localparam int SRC_TX_END_ACC   = 3;  // tx_end_from_acc
  localparam int SRC_TRY_COMPLETE = 4;  // tx_try_complete

  // Interrupt line sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  // Width of a select bus addressing n entries; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_interrupt_status_if.sv
// Register-side bundle of the tx interrupt status block. The master side is
// the PS / register file, the slave side is the status block itself.
interface tx_interrupt_status_if
  import tx_intf_irq_pkg::*;
#(
  parameter int NUM_SRC       = DEFAULT_NUM_SRC,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int HOLDOFF_WIDTH = DEFAULT_HOLDOFF_WIDTH
);

  localparam int SEL_W = sel_width(NUM_SRC);

  // Event sources and configuration
  logic [NUM_SRC-1:0]       src_event;
  logic [NUM_SRC-1:0]       irq_en_mask;
  logic                     irq_mode;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles;

  // Acknowledge and counter access strobes
  logic [NUM_SRC-1:0]       pending_clr;
  logic [SEL_W-1:0]         cnt_sel;
  logic                     cnt_clr;

  // Status back to the PS
  logic [NUM_SRC-1:0]       pending;
  logic [NUM_SRC-1:0]       overflow;
  logic [CNT_WIDTH-1:0]     cnt_out;
  logic                     tx_itrpt;

  modport master (
    output src_event, irq_en_mask, irq_mode, holdoff_cycles,
    output pending_clr, cnt_sel, cnt_clr,
    input  pending, overflow, cnt_out, tx_itrpt
  );

  modport slave (
    input  src_event, irq_en_mask, irq_mode, holdoff_cycles,
    input  pending_clr, cnt_sel, cnt_clr,
    output pending, overflow, cnt_out, tx_itrpt
  );

endinterface

// File: rtl/tx_irq_edge_capture.sv
// Per-source event capture: rising-edge detect, sticky pending and overflow
// bits, and a saturating event counter. One instance per tx event source.
module tx_irq_edge_capture #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 src_event,
  input  logic                 pending_clr,
  input  logic                 cnt_clr,
  output logic                 edge_det,
  output logic                 pending,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic                 prev_reg;
  logic                 pending_reg;
  logic                 overflow_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;

  // prev resets high so a source already asserted at reset release is not
  // mistaken for a fresh event
  assign edge_det = src_event & ~prev_reg;

  assign pending  = pending_reg;
  assign overflow = overflow_reg;
  assign cnt      = cnt_reg;

  // Track the previous source level for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= src_event;
    end
  end

  // Sticky pending/overflow; a new edge beats a simultaneous clear strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (edge_det) begin
        pending_reg <= 1'b1;
      end else if (pending_clr) begin
        pending_reg <= 1'b0;
      end

      if (edge_det && pending_reg) begin
        overflow_reg <= 1'b1;
      end else if (pending_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Saturating event count; a clear coinciding with an edge restarts at one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= edge_det ? CNT_WIDTH'(1) : '0;
    end else if (edge_det && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tx_interrupt_status.sv
// Sticky interrupt status and acknowledge block for the tx_intf path.
// Captures tx event edges per source, and sequences the single PS interrupt
// line in level or pulse mode with a programmable idle gap after each
// interrupt. Counter readback is a plain mux of the per-source counters.
module tx_interrupt_status
  import tx_intf_irq_pkg::*;
#(
  parameter int NUM_SRC       = DEFAULT_NUM_SRC,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int HOLDOFF_WIDTH = DEFAULT_HOLDOFF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  tx_interrupt_status_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_SRC);

  // State encoding kept as plain constants for compatibility with older
  // register maps that expose the state as a raw field
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ASSERT  = ASSERT;
  localparam logic [1:0] ST_HOLDOFF = HOLDOFF;

  logic [NUM_SRC-1:0]       edge_vec;
  logic [NUM_SRC-1:0]       pending_vec;
  logic [NUM_SRC-1:0]       overflow_vec;
  logic [NUM_SRC-1:0]       cnt_clr_vec;
  logic [CNT_WIDTH-1:0]     cnt_arr [NUM_SRC];

  logic [1:0]               state_reg;
  logic                     mode_reg;
  logic                     itrpt_reg;
  logic                     new_evt_reg;
  logic [HOLDOFF_WIDTH-1:0] holdoff_reg;

  logic                     irq_active;
  logic                     evt_masked;
  logic                     pulse_done;

  // One capture slice per source; the counter clear strobe only reaches the
  // slice that is currently selected for readback
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign cnt_clr_vec[gi] = bus.cnt_clr && (bus.cnt_sel == SEL_W'(gi));

    tx_irq_edge_capture #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_capture (
      .clk         (clk),
      .rstn        (rstn),
      .src_event   (bus.src_event[gi]),
      .pending_clr (bus.pending_clr[gi]),
      .cnt_clr     (cnt_clr_vec[gi]),
      .edge_det    (edge_vec[gi]),
      .pending     (pending_vec[gi]),
      .overflow    (overflow_vec[gi]),
      .cnt         (cnt_arr[gi])
    );
  end

  // Masking only gates interrupt generation; status bits are always latched
  assign irq_active = |(pending_vec & bus.irq_en_mask);
  assign evt_masked = |(edge_vec & bus.irq_en_mask);
  assign pulse_done = (state_reg == ST_ASSERT) && mode_reg;

  assign bus.pending  = pending_vec;
  assign bus.overflow = overflow_vec;
  assign bus.tx_itrpt = itrpt_reg;

  // Counter readback mux; selects beyond the last source read as zero
  always_comb begin
    bus.cnt_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.cnt_sel == SEL_W'(i)) begin
        bus.cnt_out = cnt_arr[i];
      end
    end
  end

  // Pulse-mode request: any enabled edge arms it, issuing a pulse disarms it;
  // an edge landing on the pulse cycle keeps it armed for the next pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      new_evt_reg <= 1'b0;
    end else if (evt_masked) begin
      new_evt_reg <= 1'b1;
    end else if (pulse_done) begin
      new_evt_reg <= 1'b0;
    end
  end

  // Interrupt sequencing: IDLE waits for a cause, ASSERT drives the line,
  // HOLDOFF enforces the minimum gap. Mode is latched on leaving IDLE so a
  // mode change cannot disturb an interrupt already in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= 1'b0;
      itrpt_reg   <= 1'b0;
      holdoff_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.irq_mode ? new_evt_reg : irq_active) begin
            state_reg <= ST_ASSERT;
            mode_reg  <= bus.irq_mode;
            itrpt_reg <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Pulse mode leaves after one cycle; level mode leaves once every
          // enabled pending bit is acknowledged or masked off
          if (mode_reg || !irq_active) begin
            state_reg   <= ST_HOLDOFF;
            itrpt_reg   <= 1'b0;
            holdoff_reg <= bus.holdoff_cycles;
          end
        end
        ST_HOLDOFF: begin
          if (holdoff_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            holdoff_reg <= holdoff_reg - HOLDOFF_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          itrpt_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_interrupt_status.sv
// Directed bench for tx_interrupt_status: a cycle model derived from the
// behavioural rules is compared on every falling edge, and literal checks at
// hand-computed cycles pin the model itself.
module tb_tx_interrupt_status;
  import tx_intf_irq_pkg::*;

  localparam int NS      = 5;
  localparam int CW      = 8;
  localparam int HW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  tx_interrupt_status_if #(.NUM_SRC(NS), .CNT_WIDTH(CW), .HOLDOFF_WIDTH(HW)) bus ();

  tx_interrupt_status #(
    .NUM_SRC       (NS),
    .CNT_WIDTH     (CW),
    .HOLDOFF_WIDTH (HW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [NS-1:0] m_prev     = '1;
  logic [NS-1:0] m_pending  = '0;
  logic [NS-1:0] m_overflow = '0;
  int            m_cnt [NS] = '{default: 0};
  bit            m_irq      = 1'b0;  // current interrupt line
  bit            m_pulse    = 1'b0;  // current interrupt is a pulse
  bit            m_new      = 1'b0;  // unserviced enabled event (pulse mode)
  int            m_wait     = 0;     // cycles of enforced silence still owed

  always @(posedge clk or negedge rstn) begin : model
    logic [NS-1:0] e;
    bit active;
    bit issued;
    if (!rstn) begin
      m_prev     = '1;
      m_pending  = '0;
      m_overflow = '0;
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      m_irq   = 1'b0;
      m_pulse = 1'b0;
      m_new   = 1'b0;
      m_wait  = 0;
    end else begin
      e      = bus.src_event & ~m_prev;
      active = |(m_pending & bus.irq_en_mask);
      issued = m_irq && m_pulse;
      for (int i = 0; i < NS; i++) begin
        if (bus.cnt_clr && (int'(bus.cnt_sel) == i)) m_cnt[i] = e[i] ? 1 : 0;
        else if (e[i] && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
      end
      m_overflow = (m_overflow & ~bus.pending_clr) | (e & m_pending);
      m_pending  = (m_pending & ~bus.pending_clr) | e;
      // Interrupt line: after it falls it owes holdoff+1 silent cycles,
      // then one idle cycle in which the cause is re-evaluated
      if (m_irq) begin
        if (m_pulse || !active) begin
          m_irq  = 1'b0;
          m_wait = int'(bus.holdoff_cycles) + 1;
        end
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end else if (bus.irq_mode ? m_new : active) begin
        m_irq   = 1'b1;
        m_pulse = bus.irq_mode;
      end
      if (|(e & bus.irq_en_mask)) m_new = 1'b1;
      else if (issued)            m_new = 1'b0;
      m_prev = bus.src_event;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : compare
    int exp_cnt;
    exp_cnt = 0;
    if (int'(bus.cnt_sel) < NS) exp_cnt = m_cnt[bus.cnt_sel];
    chk("cyc pending",  32'(bus.pending),  32'(m_pending));
    chk("cyc overflow", 32'(bus.overflow), 32'(m_overflow));
    chk("cyc cnt_out",  32'(bus.cnt_out),  32'(exp_cnt));
    chk("cyc tx_itrpt", 32'(bus.tx_itrpt), 32'(m_irq));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.src_event      = '0;
    bus.irq_en_mask    = '0;
    bus.irq_mode       = 1'b0;
    bus.holdoff_cycles = '0;
    bus.pending_clr    = '0;
    bus.cnt_sel        = '0;
    bus.cnt_clr        = 1'b0;

    // Reset state
    step(3);
    chk("rst pending",  32'(bus.pending),  32'h0);
    chk("rst overflow", 32'(bus.overflow), 32'h0);
    chk("rst cnt_out",  32'(bus.cnt_out),  32'h0);
    chk("rst tx_itrpt", 32'(bus.tx_itrpt), 32'h0);
    rstn = 1'b1;
    step(2);

    // Pulse mode, all enabled, holdoff 0: two edges 5 cycles apart on src 0
    bus.irq_mode       = 1'b1;
    bus.irq_en_mask    = '1;
    bus.holdoff_cycles = 16'd0;
    step(2);
    bus.src_event[SRC_TLAST] = 1'b1;           // cycle c
    step(1);
    bus.src_event[SRC_TLAST] = 1'b0;           // c+1
    chk("pulse1 pending", 32'(bus.pending[SRC_TLAST]), 32'h1);
    chk("pulse1 pre",     32'(bus.tx_itrpt), 32'h0);
    step(1);
    chk("pulse1 high",    32'(bus.tx_itrpt), 32'h1);  // c+2
    step(1);
    chk("pulse1 low",     32'(bus.tx_itrpt), 32'h0);  // c+3
    step(2);
    bus.src_event[SRC_TLAST] = 1'b1;           // c+5
    step(1);
    bus.src_event[SRC_TLAST] = 1'b0;           // c+6
    chk("pulse2 overflow", 32'(bus.overflow[SRC_TLAST]), 32'h1);
    chk("pulse2 pre",      32'(bus.tx_itrpt), 32'h0);
    step(1);
    chk("pulse2 high",     32'(bus.tx_itrpt), 32'h1); // c+7
    step(1);
    chk("pulse2 low",      32'(bus.tx_itrpt), 32'h0); // c+8
    step(10);
    chk("pulse quiet",     32'(bus.tx_itrpt), 32'h0);
    chk("pulse still pend", 32'(bus.pending[SRC_TLAST]), 32'h1);
    chk("pulse cnt0",      32'(bus.cnt_out), 32'd2);
    bus.pending_clr = '1;
    step(1);
    bus.pending_clr = '0;
    chk("clr all pending",  32'(bus.pending),  32'h0);
    chk("clr all overflow", 32'(bus.overflow), 32'h0);

    // Level mode, mask 00010, holdoff 3
    bus.irq_mode       = 1'b0;
    bus.irq_en_mask    = 5'b00010;
    bus.holdoff_cycles = 16'd3;
    step(3);
    bus.src_event[SRC_PHY_TX_START] = 1'b1;    // t0
    step(1);
    bus.src_event[SRC_PHY_TX_START] = 1'b0;    // t0+1
    chk("lvl pending", 32'(bus.pending[SRC_PHY_TX_START]), 32'h1);
    chk("lvl pre",     32'(bus.tx_itrpt), 32'h0);
    step(1);
    chk("lvl rise",    32'(bus.tx_itrpt), 32'h1);    // t0+2
    step(8);
    bus.pending_clr[SRC_PHY_TX_START] = 1'b1;  // t0+10
    step(1);
    bus.pending_clr[SRC_PHY_TX_START] = 1'b0;  // t0+11
    chk("lvl ack pend", 32'(bus.pending[SRC_PHY_TX_START]), 32'h0);
    chk("lvl ack hold", 32'(bus.tx_itrpt), 32'h1);
    bus.src_event[SRC_PHY_TX_START] = 1'b1;    // re-trigger during the gap
    step(1);
    bus.src_event[SRC_PHY_TX_START] = 1'b0;    // t0+12
    chk("lvl fall", 32'(bus.tx_itrpt), 32'h0);
    step(4);
    chk("lvl holdoff", 32'(bus.tx_itrpt), 32'h0);    // t0+16
    step(1);
    chk("lvl rerise",  32'(bus.tx_itrpt), 32'h1);    // t0+17
    bus.pending_clr[SRC_PHY_TX_START] = 1'b1;
    step(1);
    bus.pending_clr[SRC_PHY_TX_START] = 1'b0;
    step(8);

    // Same-cycle set/clear and overflow on src 3 (masked out)
    bus.src_event[SRC_TX_END_ACC]   = 1'b1;
    bus.pending_clr[SRC_TX_END_ACC] = 1'b1;
    step(1);
    bus.src_event[SRC_TX_END_ACC]   = 1'b0;
    bus.pending_clr[SRC_TX_END_ACC] = 1'b0;
    chk("setclr pending",  32'(bus.pending[SRC_TX_END_ACC]),  32'h1);
    chk("setclr overflow", 32'(bus.overflow[SRC_TX_END_ACC]), 32'h0);
    step(1);
    bus.src_event[SRC_TX_END_ACC] = 1'b1;
    step(1);
    bus.src_event[SRC_TX_END_ACC] = 1'b0;
    chk("ovf set", 32'(bus.overflow[SRC_TX_END_ACC]), 32'h1);
    step(1);
    bus.src_event[SRC_TX_END_ACC]   = 1'b1;
    bus.pending_clr[SRC_TX_END_ACC] = 1'b1;
    step(1);
    bus.src_event[SRC_TX_END_ACC]   = 1'b0;
    bus.pending_clr[SRC_TX_END_ACC] = 1'b0;
    chk("ovf collide pend", 32'(bus.pending[SRC_TX_END_ACC]),  32'h1);
    chk("ovf collide ovf",  32'(bus.overflow[SRC_TX_END_ACC]), 32'h1);
    bus.pending_clr[SRC_TX_END_ACC] = 1'b1;
    step(1);
    bus.pending_clr[SRC_TX_END_ACC] = 1'b0;
    chk("ovf cleared",  32'(bus.overflow[SRC_TX_END_ACC]), 32'h0);
    chk("pend cleared", 32'(bus.pending[SRC_TX_END_ACC]),  32'h0);

    // Masked source 4 latches status but stays silent until enabled
    bus.cnt_sel = 3'(SRC_TRY_COMPLETE);
    bus.src_event[SRC_TRY_COMPLETE] = 1'b1;
    step(1);
    bus.src_event[SRC_TRY_COMPLETE] = 1'b0;
    chk("mask pending", 32'(bus.pending[SRC_TRY_COMPLETE]), 32'h1);
    chk("mask cnt",     32'(bus.cnt_out), 32'd1);
    step(3);
    chk("mask silent",  32'(bus.tx_itrpt), 32'h0);
    bus.irq_en_mask = 5'b10010;
    step(2);
    chk("unmask rise",  32'(bus.tx_itrpt), 32'h1);
    bus.pending_clr[SRC_TRY_COMPLETE] = 1'b1;
    step(1);
    bus.pending_clr[SRC_TRY_COMPLETE] = 1'b0;
    step(1);
    chk("unmask ack",   32'(bus.tx_itrpt), 32'h0);
    step(8);

    // Counter saturation on src 2, readback select bounds, clear with edge
    bus.cnt_sel = 3'(SRC_TX_START_ACC);
    for (int k = 0; k < 300; k++) begin
      bus.src_event[SRC_TX_START_ACC] = 1'b1;
      step(1);
      bus.src_event[SRC_TX_START_ACC] = 1'b0;
      step(1);
    end
    chk("sat cnt", 32'(bus.cnt_out), 32'd255);
    bus.cnt_sel = 3'd5;
    #1;
    chk("sel oob", 32'(bus.cnt_out), 32'd0);
    bus.cnt_sel = 3'(SRC_TX_START_ACC);
    bus.src_event[SRC_TX_START_ACC] = 1'b1;
    bus.cnt_clr = 1'b1;
    step(1);
    bus.src_event[SRC_TX_START_ACC] = 1'b0;
    bus.cnt_clr = 1'b0;
    chk("clr with edge", 32'(bus.cnt_out), 32'd1);
    bus.cnt_clr = 1'b1;
    step(1);
    bus.cnt_clr = 1'b0;
    chk("clr alone", 32'(bus.cnt_out), 32'd0);
    bus.pending_clr = '1;
    step(1);
    bus.pending_clr = '0;

    // Reset mid-ASSERT with src 0 held high
    bus.irq_en_mask = 5'b00001;
    bus.cnt_sel     = 3'(SRC_TLAST);
    step(10);
    bus.src_event[SRC_TLAST] = 1'b1;
    step(3);
    chk("pre-rst assert", 32'(bus.tx_itrpt), 32'h1);
    chk("pre-rst cnt0",   32'(bus.cnt_out),  32'd3);
    rstn = 1'b0;
    #1;
    chk("async rst tx",   32'(bus.tx_itrpt), 32'h0);
    chk("async rst pend", 32'(bus.pending),  32'h0);
    chk("async rst ovf",  32'(bus.overflow), 32'h0);
    chk("async rst cnt",  32'(bus.cnt_out),  32'h0);
    step(2);
    rstn = 1'b1;
    step(5);
    chk("held no edge",    32'(bus.pending[SRC_TLAST]), 32'h0);
    chk("held no irq",     32'(bus.tx_itrpt), 32'h0);
    bus.src_event[SRC_TLAST] = 1'b0;
    step(1);
    bus.src_event[SRC_TLAST] = 1'b1;
    step(1);
    chk("retoggle pend",   32'(bus.pending[SRC_TLAST]), 32'h1);
    step(1);
    chk("retoggle irq",    32'(bus.tx_itrpt), 32'h1);
    bus.src_event[SRC_TLAST] = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_interrupt_status.md
# tx_interrupt_status

Sticky interrupt status and acknowledge block for the tx_intf path; it is the consumer side of the tx interrupt source vector. Each tx event source is rising-edge detected and latched into a pending bit, counted, and gated by an enable mask. The block drives a single PS interrupt line in level or pulse mode with a programmable hold-off, and the PS clears pending bits with write-1-to-clear strobes.

## Interface
Parameters:
- NUM_SRC, 5, number of event sources; index 0 s00_axis_tlast, 1 phy_tx_start, 2 tx_start_from_acc, 3 tx_end_from_acc, 4 tx_try_complete
- CNT_WIDTH, 8, per-source saturating event counter width
- HOLDOFF_WIDTH, 16, hold-off counter width

Ports:
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- src_event  in  NUM_SRC  raw source levels or pulses, synchronous to clk
- irq_en_mask  in  NUM_SRC  1 = source may raise the interrupt
- irq_mode  in  1  0 = level, 1 = pulse
- holdoff_cycles  in  HOLDOFF_WIDTH  minimum idle gap after each interrupt
- pending_clr  in  NUM_SRC  one-cycle write-1-to-clear strobe for pending and overflow bits
- cnt_sel  in  $clog2(NUM_SRC)  counter readback select
- cnt_clr  in  1  one-cycle strobe; clears the selected counter
- pending  out  NUM_SRC  sticky pending bits
- overflow  out  NUM_SRC  sticky: an edge arrived while the bit was already pending
- cnt_out  out  CNT_WIDTH  selected counter value (combinational mux of registers); 0 when cnt_sel >= NUM_SRC
- tx_itrpt  out  1  interrupt to PS, registered

## Operation
- Edge detect: edge[i] = src_event[i] & ~prev[i]. prev resets to all-ones, so a source held high through reset release does not fire.
- Pending: an edge sets pending[i]. pending_clr[i] clears it. Set and clear in the same cycle: set wins.
- Overflow: an edge while pending[i] = 1 sets overflow[i]. It is cleared by pending_clr[i], with set winning on a collision.
- Masking affects only interrupt generation. Masked sources still latch pending, overflow and counts.
- Counters: each edge increments cnt[i], saturating at all-ones. cnt_clr together with an edge on the selected source gives 1.
- new_evt flag: set by any edge on a masked-in source; cleared when a pulse is issued. It is used in pulse mode only.
- FSM states:
  - IDLE: go to ASSERT if any(pending & irq_en_mask) (level mode) or new_evt (pulse mode).
  - ASSERT: in level mode, tx_itrpt stays 1 while any(pending & irq_en_mask); when that drops to 0, load the hold-off counter and go to HOLDOFF. In pulse mode, tx_itrpt is 1 for exactly one cycle, new_evt is cleared, then go to HOLDOFF.
  - HOLDOFF: tx_itrpt = 0. Count down from holdoff_cycles; when the count is 0, go to IDLE. holdoff_cycles = 0 gives one HOLDOFF cycle.
- irq_mode changes take effect in IDLE only; they are sampled on the IDLE to ASSERT transition.
- Clearing the mask mid-ASSERT (level mode) deasserts the interrupt and enters HOLDOFF like a normal acknowledge.

## Timing
- Reset values: pending = 0, overflow = 0, all counters = 0, tx_itrpt = 0, FSM = IDLE, new_evt = 0, prev = all-ones.
- Edge sampled at cycle N: pending, overflow and cnt update at N+1.
- tx_itrpt rises at N+2, with FSM in IDLE and the source enabled.
- pending_clr at cycle M: pending clears at M+1. In level mode tx_itrpt falls at M+2 if no other masked bit is pending.
- After tx_itrpt falls, it stays low for holdoff_cycles + 1 cycles minimum.
- Asserting rstn low at any time forces all outputs to reset values immediately (asynchronously). A pulse in flight is dropped.

## Structure
- Package tx_intf_irq_pkg holds:
  - the FSM state enum: IDLE, ASSERT, HOLDOFF
  - source index constants: SRC_TLAST = 0, SRC_PHY_TX_START = 1, SRC_TX_START_ACC = 2, SRC_TX_END_ACC = 3, SRC_TRY_COMPLETE = 4
  - default NUM_SRC
- Sub-module tx_irq_edge_capture: per-source prev register, edge detect, pending, overflow and saturating counter. It is instantiated NUM_SRC times.
- The top level holds the FSM, the hold-off counter, new_evt and the cnt_out mux.

## Test plan
- Level mode, mask = 5'b00010, holdoff = 3: 1-cycle src_event[1] pulse at cycle 10 → pending[1] at 11, tx_itrpt at 12. pending_clr[1] at 20 → tx_itrpt low at 22, cannot rise again before 26.
- Same-cycle set/clear: edge on src 3 with pending_clr[3] in the same cycle → pending[3] stays 1. A second edge before the clear → overflow[3] = 1.
- Pulse mode, mask = all-ones, holdoff = 0: two edges 5 cycles apart on src 0 → two single-cycle tx_itrpt pulses. With no new edge there is no further pulse while pending remains set.
- Masked source: edge on src 4 with mask[4] = 0 → pending[4] = 1, cnt[4] = 1, tx_itrpt stays 0. Setting mask[4] = 1 in level mode → tx_itrpt rises within 2 cycles.
- Counter saturation: 300 edges on src 2 with CNT_WIDTH = 8 → cnt_out = 255 with cnt_sel = 2. cnt_clr together with an edge → 1.
- Reset: src_event[0] held high, rstn pulsed low mid-ASSERT → tx_itrpt = 0 immediately, all status 0, and no edge after release until src_event[0] toggles low then high.
